// File: rtl/console_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : console_uart_tx                                                   |
// | Brief   : Byte FIFO plus 8N1 UART serializer for the bbq console stream.     |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module console_uart_tx #(
  parameter int XLEN         = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            console_we,
  input  logic [XLEN-1:0] console_wdata,
  output logic            tx,
  output logic            busy,
  output logic            fifo_full,
  output logic            overflow,
  output logic [7:0]      drop_count
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW = c_AW + 1;
  localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  logic [7:0]      r_drop_count;

  // Serializer state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_BW-1:0] r_baud;
  logic [c_BW-1:0] w_baud_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            r_tx;
  logic            w_tx_nxt;

  logic            w_empty;
  logic            w_full;
  logic            w_wrap;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [7:0]      w_head;

  generate
    if (XLEN > 8) begin : g_unused_hi
      logic w_unused_wdata;
      assign w_unused_wdata = ^console_wdata[XLEN-1:8];
    end
  endgenerate

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_wrap  = (r_baud == c_BAUD_LAST);
  assign w_head  = r_mem[r_rd_ptr];

  // A full FIFO still accepts a write when the serializer pops at the same edge.
  assign w_push  = console_we & (~w_full | w_pop);
  assign w_drop  = console_we & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= console_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 8'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_tx_nxt    = 1'b0;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_wrap) begin
          w_baud_nxt  = '0;
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = 3'd0;
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_tx_nxt    = 1'b0;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) | ~w_empty;
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_console_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_console_uart_tx                                                |
// | Brief   : Directed self-checking bench for console_uart_tx.                  |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_console_uart_tx;

  localparam int XLEN = 32;
  localparam int CPB  = 4;
  localparam int DEP  = 4;

  logic            clk;
  logic            reset;
  logic            console_we;
  logic [XLEN-1:0] console_wdata;
  logic            tx;
  logic            busy;
  logic            fifo_full;
  logic            overflow;
  logic [7:0]      drop_count;

  int checks;
  int errors;

  console_uart_tx #(
    .XLEN        (XLEN),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .console_we   (console_we),
    .console_wdata(console_wdata),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each frame is {stop, data[7:0], start}; bit 0 goes on the line first.
  task automatic test_reset();
    reset = 1'b0;
    console_we = 1'b0;
    console_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: tx=%b busy=%b full=%b required tx=1 busy=0 full=0", tx, busy, fifo_full);
    end
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: tx=%b busy=%b ovf=%b drops=%0d required 1 0 0 0",
                 c, tx, busy, overflow, drop_count);
      end
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    frame = 10'b1010000010;  // 0x41
    for (int c = 1; c <= 42; c++) begin
      console_we = (c == 1);
      console_wdata = 32'h0000_0041;
      @(posedge clk);
      #1;
      console_we = 1'b0;
      if (c >= 2 && c <= 41) begin
        checks++;
        if (tx !== frame[(c-2)/CPB]) begin
          errors++;
          $display("FAIL single_tx c=%0d: tx=%b required %b", c, tx, frame[(c-2)/CPB]);
        end
      end
      if (c == 41) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_hold: busy=%b required 1", busy);
        end
      end
      if (c == 42) begin
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
          errors++;
          $display("FAIL single_busy_fall: busy=%b tx=%b required 0 1", busy, tx);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] stream;
    stream = {10'b1011010010, 10'b1010010000};  // 0x69 after 0x48
    for (int c = 1; c <= 82; c++) begin
      console_we = (c <= 2);
      console_wdata = (c == 1) ? 32'h48 : 32'h69;
      @(posedge clk);
      #1;
      console_we = 1'b0;
      if (c >= 2 && c <= 81) begin
        checks++;
        if (tx !== stream[(c-2)/CPB]) begin
          errors++;
          $display("FAIL b2b_tx c=%0d: tx=%b required %b", c, tx, stream[(c-2)/CPB]);
        end
      end
      if (c == 82) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_busy_fall: busy=%b required 0", busy);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [49:0] stream;
    stream = {10'b1001101000, 10'b1001100110, 10'b1001100100,
              10'b1001100010, 10'b1001100000};  // 0x34..0x30
    for (int c = 1; c <= 202; c++) begin
      console_we = (c <= 6);
      console_wdata = 32'h30 + 32'(c - 1);
      @(posedge clk);
      #1;
      console_we = 1'b0;
      if (c == 4) begin
        checks++;
        if (fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL ovf_not_full: full=%b required 0", fifo_full);
        end
      end
      if (c == 5) begin
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full: full=%b ovf=%b required 1 0", fifo_full, overflow);
        end
      end
      if (c == 6) begin
        checks++;
        if (overflow !== 1'b1 || drop_count !== 8'd1) begin
          errors++;
          $display("FAIL ovf_drop: ovf=%b drops=%0d required 1 1", overflow, drop_count);
        end
      end
      if (c >= 2 && c <= 201) begin
        checks++;
        if (tx !== stream[(c-2)/CPB]) begin
          errors++;
          $display("FAIL ovf_tx c=%0d: tx=%b required %b", c, tx, stream[(c-2)/CPB]);
        end
      end
      if (c == 202) begin
        checks++;
        if (busy !== 1'b0 || drop_count !== 8'd1) begin
          errors++;
          $display("FAIL ovf_end: busy=%b drops=%0d required 0 1", busy, drop_count);
        end
      end
    end
  endtask

  task automatic test_wdata_mask();
    logic [9:0] frame;
    frame = 10'b1000010100;  // 0x0A
    for (int c = 1; c <= 42; c++) begin
      console_we = (c == 1);
      console_wdata = 32'hFFFF_FF0A;
      @(posedge clk);
      #1;
      console_we = 1'b0;
      if (c >= 2 && c <= 41) begin
        checks++;
        if (tx !== frame[(c-2)/CPB]) begin
          errors++;
          $display("FAIL mask_tx c=%0d: tx=%b required %b", c, tx, frame[(c-2)/CPB]);
        end
      end
      if (c == 42) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL mask_busy_fall: busy=%b required 0", busy);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    // 0x41: start at edges 2..5, data bit k after edges 6+4k..9+4k; bit 3 = 0.
    for (int c = 1; c <= 19; c++) begin
      console_we = (c == 1);
      console_wdata = 32'h41;
      @(posedge clk);
      #1;
      console_we = 1'b0;
    end
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: tx=%b busy=%b required 0 1", tx, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 || fifo_full !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate: tx=%b busy=%b ovf=%b drops=%0d full=%b required 1 0 0 0 0",
               tx, busy, overflow, drop_count, fifo_full);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL arst_after c=%0d: tx=%b busy=%b required 1 0", c, tx, busy);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_wdata_mask();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
